// File: rtl/multi_alarm_clock_if.sv
// Control/status bundle for multi_alarm_clock: user controls, alarm edits and
// time/alarm/buzzer status. Master drives controls, slave is the clock core.
interface multi_alarm_clock_if #(
   parameter int unsigned NUM_ALARMS = 4,
   parameter int unsigned DAYS       = 7
);
   localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

   logic            tick;
   logic            Timeset;
   logic            Alarmset;
   logic            Minadv;
   logic            Hrsadv;
   logic            Dayadv;
   logic            Alarmon;
   logic [AW-1:0]   alm_sel;
   logic [DAYS-1:0] alm_mask_in;
   logic            alm_mask_we;
   logic            alm_arm_in;
   logic            alm_arm_we;
   logic            snooze;
   logic            dismiss;

   logic [5:0]      tsec;
   logic [5:0]      tmin;
   logic [4:0]      thrs;
   logic [2:0]      tday;
   logic [5:0]      amin;
   logic [4:0]      ahrs;
   logic [DAYS-1:0] amask;
   logic [AW-1:0]   active_alm;
   logic            ringing;
   logic            snoozing;
   logic            Buzz;

   modport master (
      output tick, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon,
             alm_sel, alm_mask_in, alm_mask_we, alm_arm_in, alm_arm_we,
             snooze, dismiss,
      input  tsec, tmin, thrs, tday, amin, ahrs, amask, active_alm,
             ringing, snoozing, Buzz
   );

   modport slave (
      input  tick, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon,
             alm_sel, alm_mask_in, alm_mask_we, alm_arm_in, alm_arm_we,
             snooze, dismiss,
      output tsec, tmin, thrs, tday, amin, ahrs, amask, active_alm,
             ringing, snoozing, Buzz
   );
endinterface

// File: rtl/multi_alarm_clock.sv
// Time-of-day/day-of-week clock with NUM_ALARMS alarm channels and a ring FSM.
// Optional snooze state/counter built when ALARM_SNOOZE_EN is defined.
module multi_alarm_clock #(
   parameter int unsigned NUM_ALARMS = 4,
   parameter int unsigned DAYS       = 7,
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned SNOOZE_SEC = 300
) (
   input  logic               clk,
   input  logic               rst_n,
   multi_alarm_clock_if.slave bus
);
   localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
`ifdef ALARM_SNOOZE_EN
   localparam int unsigned TMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;
`else
   localparam int unsigned TMAX = RING_SEC;
   typedef enum logic [0:0] {S_IDLE, S_RING} state_t;
`endif
   localparam int unsigned CW = $clog2(TMAX + 1);

   logic [5:0]      sec_q, sec_d, min_q, min_d;
   logic [4:0]      hrs_q, hrs_d;
   logic [2:0]      day_q, day_d;
   logic            roll_q, roll_d;
   logic [5:0]      amin_q [NUM_ALARMS];
   logic [5:0]      amin_d [NUM_ALARMS];
   logic [4:0]      ahrs_q [NUM_ALARMS];
   logic [4:0]      ahrs_d [NUM_ALARMS];
   logic [DAYS-1:0] amask_q [NUM_ALARMS];
   logic [DAYS-1:0] amask_d [NUM_ALARMS];
   logic            arm_q [NUM_ALARMS];
   logic            arm_d [NUM_ALARMS];
   logic [5:0]      amin_o_q;
   logic [4:0]      ahrs_o_q;
   logic [DAYS-1:0] amask_o_q;
   logic            sel_ok;
   logic            match_any;
   logic [AW-1:0]   match_idx;
   logic            hit;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   act_q, act_d;
   logic            ringing_q;

   assign sel_ok = (32'(bus.alm_sel) < NUM_ALARMS);

   // Time chain: normal carry when running, independent field advance in Timeset.
   always_comb begin
      sec_d  = sec_q;
      min_d  = min_q;
      hrs_d  = hrs_q;
      day_d  = day_q;
      roll_d = 1'b0;
      if (bus.tick) begin
         if (bus.Timeset) begin
            if (bus.Minadv) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (bus.Hrsadv) hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
            if (bus.Dayadv) day_d = (day_q == 3'(DAYS - 1)) ? 3'd0 : day_q + 3'd1;
         end else begin
            roll_d = (sec_q == 6'd59);
            sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
               min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
               if (min_q == 6'd59) begin
                  hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
                  if (hrs_q == 5'd23)
                     day_d = (day_q == 3'(DAYS - 1)) ? 3'd0 : day_q + 3'd1;
               end
            end
         end
      end
   end

   // Alarm channel edits: tick-paced HH:MM advance plus direct mask/arm writes.
   always_comb begin
      amin_d  = amin_q;
      ahrs_d  = ahrs_q;
      amask_d = amask_q;
      arm_d   = arm_q;
      if (sel_ok) begin
         if (bus.tick && bus.Alarmset && !bus.Timeset) begin
            if (bus.Minadv)
               amin_d[bus.alm_sel] = (amin_q[bus.alm_sel] == 6'd59) ? 6'd0 : amin_q[bus.alm_sel] + 6'd1;
            if (bus.Hrsadv)
               ahrs_d[bus.alm_sel] = (ahrs_q[bus.alm_sel] == 5'd23) ? 5'd0 : ahrs_q[bus.alm_sel] + 5'd1;
         end
         if (bus.alm_mask_we) amask_d[bus.alm_sel] = bus.alm_mask_in;
         if (bus.alm_arm_we)  arm_d[bus.alm_sel]   = bus.alm_arm_in;
      end
   end

   // Lowest armed channel whose HH:MM/day matches the freshly rolled time.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
         if (arm_q[i] && amask_q[i][day_q] && ahrs_q[i] == hrs_q && amin_q[i] == min_q) begin
            match_any = 1'b1;
            match_idx = AW'(i);
         end
      end
   end

   assign hit = roll_q && bus.Alarmon && match_any;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      unique case (state_q)
         S_IDLE: begin
            if (!bus.dismiss && hit) begin
               state_d = S_RING;
               cnt_d   = CW'(RING_SEC);
               act_d   = match_idx;
            end
         end
         S_RING: begin
            if (bus.dismiss || !bus.Alarmon) begin
               state_d = S_IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (bus.snooze) begin
               state_d = S_SNOOZE;
               cnt_d   = CW'(SNOOZE_SEC);
`endif
            end else if (bus.tick) begin
               if (cnt_q == CW'(1)) state_d = S_IDLE;
               else                 cnt_d   = cnt_q - CW'(1);
            end
         end
`ifdef ALARM_SNOOZE_EN
         S_SNOOZE: begin
            if (bus.dismiss || !bus.Alarmon) begin
               state_d = S_IDLE;
            end else if (bus.tick && cnt_q == CW'(1)) begin
               state_d = S_RING;
               cnt_d   = CW'(RING_SEC);
            end else if (hit) begin
               state_d = S_RING;
               cnt_d   = CW'(RING_SEC);
               act_d   = match_idx;
            end else if (bus.tick) begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_q     <= '0;
         min_q     <= '0;
         hrs_q     <= '0;
         day_q     <= '0;
         roll_q    <= 1'b0;
         for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            amin_q[i]  <= '0;
            ahrs_q[i]  <= '0;
            amask_q[i] <= '1;
            arm_q[i]   <= 1'b0;
         end
         amin_o_q  <= '0;
         ahrs_o_q  <= '0;
         amask_o_q <= '1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         act_q     <= '0;
         ringing_q <= 1'b0;
      end else begin
         sec_q     <= sec_d;
         min_q     <= min_d;
         hrs_q     <= hrs_d;
         day_q     <= day_d;
         roll_q    <= roll_d;
         amin_q    <= amin_d;
         ahrs_q    <= ahrs_d;
         amask_q   <= amask_d;
         arm_q     <= arm_d;
         amin_o_q  <= sel_ok ? amin_d[bus.alm_sel]  : '0;
         ahrs_o_q  <= sel_ok ? ahrs_d[bus.alm_sel]  : '0;
         amask_o_q <= sel_ok ? amask_d[bus.alm_sel] : '0;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act_q     <= act_d;
         ringing_q <= (state_d == S_RING);
      end
   end

`ifdef ALARM_SNOOZE_EN
   logic snoozing_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) snoozing_q <= 1'b0;
      else        snoozing_q <= (state_d == S_SNOOZE);
   end
   assign bus.snoozing = snoozing_q;
`else
   logic [31:0] unused_snooze;
   assign unused_snooze = {bus.snooze, 31'(SNOOZE_SEC)};
   assign bus.snoozing  = 1'b0;
`endif

   assign bus.tsec       = sec_q;
   assign bus.tmin       = min_q;
   assign bus.thrs       = hrs_q;
   assign bus.tday       = day_q;
   assign bus.amin       = amin_o_q;
   assign bus.ahrs       = ahrs_o_q;
   assign bus.amask      = amask_o_q;
   assign bus.active_alm = act_q;
   assign bus.ringing    = ringing_q;
   assign bus.Buzz       = ringing_q;
endmodule
